// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between IF fetch and MEM load/store
// Fixed priority to MEM, with IF forced through after STARVE_MAX consecutive MEM wins.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);
    localparam logic [2:0]    LAT_INIT = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IF,
        WAIT_DM
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    lat_cnt, lat_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic          force_if;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
            streak  <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            streak  <= streak_nxt;
        end
    end

    assign force_if = if_req && (streak == SMAX);

    // Outputs are held at zero while reset is high, even with requests pending.
    always_comb begin
        state_nxt  = state;
        lat_nxt    = lat_cnt;
        streak_nxt = streak;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        dm_rvalid  = 1'b0;
        if_rdata   = 32'd0;
        dm_rdata   = 32'd0;
        mem_en     = 1'b0;
        mem_we     = 4'd0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (dm_req && !force_if) begin
                        dm_gnt    = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = dm_we ? dm_be : 4'd0;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        lat_nxt   = LAT_INIT;
                        state_nxt = WAIT_DM;
                        if (!if_req)
                            streak_nxt = '0;
                        else if (streak != SMAX)
                            streak_nxt = streak + SW'(1);
                    end else if (if_req) begin
                        if_gnt     = 1'b1;
                        mem_en     = 1'b1;
                        mem_addr   = if_addr;
                        lat_nxt    = LAT_INIT;
                        state_nxt  = WAIT_IF;
                        streak_nxt = '0;
                    end else begin
                        streak_nxt = '0;
                    end
                end
                WAIT_IF: begin
                    if (lat_cnt == 3'd0) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                        state_nxt = IDLE;
                    end else begin
                        lat_nxt = lat_cnt - 3'd1;
                    end
                end
                WAIT_DM: begin
                    if (lat_cnt == 3'd0) begin
                        dm_rvalid = 1'b1;
                        dm_rdata  = mem_rdata;
                        state_nxt = IDLE;
                    end else begin
                        lat_nxt = lat_cnt - 3'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (MEM_LAT 1 and 3)
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        en1, en3;

    logic        if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, mem_en1, busy1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
    logic [31:0] mem_rdata1 = 32'd0;
    logic [3:0]  mem_we1;
    logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, mem_en3, busy3;
    logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic [3:0]  mem_we3;
    logic [31:0] p3 [3];

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req & en1), .if_addr(if_addr), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .dm_req(dm_req & en1), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req & en3), .if_addr(if_addr), .if_gnt(if_gnt3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .dm_req(dm_req & en3), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    // Memory models: data appears exactly MEM_LAT cycles after the access strobe.
    always @(posedge clk) if (mem_en1) mem_rdata1 <= mdata(mem_addr1);
    always @(posedge clk) begin
        p3[0] <= mem_en3 ? mdata(mem_addr3) : 32'd0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata3 = p3[2];

    typedef struct {
        logic        dm;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        ifr, dmr, we;
        logic [3:0]  be;
        logic [31:0] ia, da;
        logic        eig, edg;
        logic [3:0]  ewe;
        logic        ebusy;
    } vec_t;

    exp_t q1[$];
    exp_t q3[$];
    vec_t vt[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic sample();
        exp_t e;
        @(negedge clk);
        chk1("gnt1_onehot", if_gnt1 & dm_gnt1, 1'b0);
        chk1("rv1_onehot", if_rvalid1 & dm_rvalid1, 1'b0);
        chk1("en1_eq_gnt", mem_en1, if_gnt1 | dm_gnt1);
        chk1("gnt3_onehot", if_gnt3 & dm_gnt3, 1'b0);
        chk1("rv3_onehot", if_rvalid3 & dm_rvalid3, 1'b0);
        chk1("en3_eq_gnt", mem_en3, if_gnt3 | dm_gnt3);
        if (!if_rvalid1) chk32("if_rdata1_zero", if_rdata1, 32'd0);
        if (!dm_rvalid1) chk32("dm_rdata1_zero", dm_rdata1, 32'd0);
        if (!if_rvalid3) chk32("if_rdata3_zero", if_rdata3, 32'd0);
        if (!dm_rvalid3) chk32("dm_rdata3_zero", dm_rdata3, 32'd0);
        if (q1.size() > 0 && q1[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL rsp1_missing due=%0d cyc=%0d", q1[0].due, cyc);
            void'(q1.pop_front());
        end
        if (q3.size() > 0 && q3[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL rsp3_missing due=%0d cyc=%0d", q3[0].due, cyc);
            void'(q3.pop_front());
        end
        if (if_rvalid1 || dm_rvalid1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp1_unexpected cyc=%0d", cyc);
            end else begin
                e = q1.pop_front();
                chk1("rsp1_port", dm_rvalid1, e.dm);
                chk32("rsp1_data", if_rvalid1 ? if_rdata1 : dm_rdata1, e.data);
                chk32("rsp1_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (if_rvalid3 || dm_rvalid3) begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp3_unexpected cyc=%0d", cyc);
            end else begin
                e = q3.pop_front();
                chk1("rsp3_port", dm_rvalid3, e.dm);
                chk32("rsp3_data", if_rvalid3 ? if_rdata3 : dm_rdata3, e.data);
                chk32("rsp3_cycle", 32'(cyc), 32'(e.due));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic vec_t mkv(input logic ifr, input logic dmr, input logic we,
                                 input logic [3:0] be, input logic [31:0] ia,
                                 input logic [31:0] da, input logic eig, input logic edg,
                                 input logic [3:0] ewe, input logic ebusy);
        vec_t v;
        v.ifr = ifr; v.dmr = dmr; v.we = we; v.be = be; v.ia = ia; v.da = da;
        v.eig = eig; v.edg = edg; v.ewe = ewe; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic drive(input logic ifr, input logic dmr, input logic [31:0] ia,
                         input logic [31:0] da);
        if_req = ifr; dm_req = dmr; if_addr = ia; dm_addr = da;
        dm_we = 1'b0; dm_be = 4'd0; dm_wdata = ~da;
    endtask

    localparam logic [31:0] IA0 = 32'h0040_0000;
    localparam logic [31:0] IA1 = 32'h0040_0004;
    localparam logic [31:0] IA2 = 32'h0040_0008;
    localparam logic [31:0] IA3 = 32'h0040_0100;
    localparam logic [31:0] DA0 = 32'h1001_0000;
    localparam logic [31:0] DST = 32'h1001_0004;

    initial begin
        // ifr dmr we be ia da -> if_gnt dm_gnt mem_we busy
        vt.push_back(mkv(0, 0, 0, 4'h0, IA0, DA0,      0, 0, 4'h0, 0));
        vt.push_back(mkv(1, 0, 0, 4'h0, IA0, DA0,      1, 0, 4'h0, 0));
        vt.push_back(mkv(1, 0, 0, 4'h0, IA1, DA0,      0, 0, 4'h0, 1));
        vt.push_back(mkv(1, 0, 0, 4'h0, IA1, DA0,      1, 0, 4'h0, 0));
        vt.push_back(mkv(0, 0, 0, 4'h0, IA1, DA0,      0, 0, 4'h0, 1));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA2, DA0,      0, 1, 4'h0, 0));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA2, DA0,      0, 0, 4'h0, 1));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA2, DA0 + 16, 0, 1, 4'h0, 0));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA2, DA0 + 16, 0, 0, 4'h0, 1));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA2, DA0 + 32, 0, 1, 4'h0, 0));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA2, DA0 + 32, 0, 0, 4'h0, 1));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA2, DA0 + 48, 0, 1, 4'h0, 0));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA2, DA0 + 48, 0, 0, 4'h0, 1));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA2, DA0 + 64, 1, 0, 4'h0, 0));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA1, DA0 + 64, 0, 0, 4'h0, 1));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA1, DA0 + 64, 0, 1, 4'h0, 0));
        vt.push_back(mkv(1, 1, 0, 4'h0, IA1, DA0 + 64, 0, 0, 4'h0, 1));
        vt.push_back(mkv(0, 0, 0, 4'h0, IA1, DA0,      0, 0, 4'h0, 0));
        vt.push_back(mkv(0, 1, 1, 4'h3, IA1, DST,      0, 1, 4'h3, 0));
        vt.push_back(mkv(0, 0, 0, 4'h0, IA1, DST,      0, 0, 4'h0, 1));
        vt.push_back(mkv(0, 1, 0, 4'h0, IA1, DA0 + 32, 0, 1, 4'h0, 0));
        vt.push_back(mkv(1, 0, 0, 4'h0, IA3, DA0,      0, 0, 4'h0, 1));
        vt.push_back(mkv(0, 0, 0, 4'h0, IA3, DA0,      0, 0, 4'h0, 0));
        vt.push_back(mkv(1, 0, 0, 4'h0, IA3, DA0,      1, 0, 4'h0, 0));
        vt.push_back(mkv(0, 0, 0, 4'h0, IA3, DA0,      0, 0, 4'h0, 1));

        reset = 1'b1; en1 = 1'b1; en3 = 1'b0;
        drive(0, 0, 32'd0, 32'd0);
        sample();
        chk1("rst_if_gnt", if_gnt1, 1'b0);
        chk1("rst_dm_gnt", dm_gnt1, 1'b0);
        chk1("rst_mem_en", mem_en1, 1'b0);
        chk1("rst_busy", busy1, 1'b0);
        chk32("rst_mem_addr", mem_addr1, 32'd0);
        adv();
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            if_req = vt[i].ifr; dm_req = vt[i].dmr; dm_we = vt[i].we; dm_be = vt[i].be;
            if_addr = vt[i].ia; dm_addr = vt[i].da; dm_wdata = ~vt[i].da;
            if (vt[i].eig) q1.push_back('{1'b0, mdata(vt[i].ia), cyc + 1});
            if (vt[i].edg) q1.push_back('{1'b1, mdata(vt[i].da), cyc + 1});
            sample();
            chk1($sformatf("v%0d_if_gnt", i), if_gnt1, vt[i].eig);
            chk1($sformatf("v%0d_dm_gnt", i), dm_gnt1, vt[i].edg);
            chk32($sformatf("v%0d_mem_we", i), 32'(mem_we1), 32'(vt[i].ewe));
            chk1($sformatf("v%0d_busy", i), busy1, vt[i].ebusy);
            chk32($sformatf("v%0d_mem_addr", i), mem_addr1,
                  vt[i].edg ? vt[i].da : (vt[i].eig ? vt[i].ia : 32'd0));
            chk32($sformatf("v%0d_mem_wdata", i), mem_wdata1,
                  vt[i].edg ? ~vt[i].da : 32'd0);
            adv();
        end
        drive(0, 0, 32'd0, 32'd0);
        for (int k = 0; k < 10 && q1.size() > 0; k++) begin sample(); adv(); end

        // MEM_LAT=3 load: rvalid three cycles after grant, requests ignored meanwhile
        en1 = 1'b0; en3 = 1'b1;
        sample(); adv();
        drive(0, 1, IA0, 32'h1001_0008);
        q3.push_back('{1'b1, mdata(32'h1001_0008), cyc + 3});
        sample();
        chk1("l3_dm_gnt", dm_gnt3, 1'b1);
        chk1("l3_busy_gnt", busy3, 1'b0);
        adv();
        drive(1, 1, IA1, 32'h1001_000C);
        for (int k = 0; k < 3; k++) begin
            sample();
            chk1($sformatf("l3_wait%0d_if_gnt", k), if_gnt3, 1'b0);
            chk1($sformatf("l3_wait%0d_dm_gnt", k), dm_gnt3, 1'b0);
            chk1($sformatf("l3_wait%0d_busy", k), busy3, 1'b1);
            adv();
        end
        q3.push_back('{1'b1, mdata(32'h1001_000C), cyc + 3});
        sample();
        chk1("l3_regrant_dm", dm_gnt3, 1'b1);
        adv();
        drive(0, 0, 32'd0, 32'd0);
        for (int k = 0; k < 10 && q3.size() > 0; k++) begin sample(); adv(); end
        sample(); adv();

        // Reset while WAIT_DM with lat_cnt==1: abort, no stale rvalid afterwards
        drive(0, 1, IA0, 32'h1001_0010);
        q3.push_back('{1'b1, mdata(32'h1001_0010), cyc + 3});
        sample();
        chk1("rs_dm_gnt", dm_gnt3, 1'b1);
        adv();
        drive(0, 0, 32'd0, 32'd0);
        sample(); adv();
        reset = 1'b1;
        drive(1, 1, IA2, 32'h1001_0014);
        q3.delete();
        sample();
        chk1("rs_busy0", busy3, 1'b0);
        chk1("rs_dm_gnt0", dm_gnt3, 1'b0);
        chk1("rs_if_gnt0", if_gnt3, 1'b0);
        chk1("rs_mem_en0", mem_en3, 1'b0);
        chk32("rs_mem_addr0", mem_addr3, 32'd0);
        adv();
        sample(); adv();
        reset = 1'b0;
        q3.push_back('{1'b1, mdata(32'h1001_0014), cyc + 3});
        sample();
        chk1("rs_post_dm_gnt", dm_gnt3, 1'b1);
        chk1("rs_post_if_gnt", if_gnt3, 1'b0);
        adv();
        drive(0, 0, 32'd0, 32'd0);
        for (int k = 0; k < 6; k++) begin sample(); adv(); end

        chk32("q1_drained", 32'(q1.size()), 32'd0);
        chk32("q3_drained", 32'(q3.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
